// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: sub-word extract/merge, req/ready RAM port, timeout
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [29:0] ramAddress,
  output logic        ramReadReq,
  output logic        ramWriteReq,
  output logic [31:0] ramWriteData,
  input  logic [31:0] ramReadData,
  input  logic        ramReady,
  output logic [31:0] memoryOutput,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        accessFault
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} lsuState;
  localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES;

  lsuState     state, stateNext;
  logic        reqIsStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddress;
  logic [15:0] reqStoreData;
  logic [31:0] timeoutCount;
  logic        startIllegal, startMisaligned, timeoutHit;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadFormatted, mergedWord;

  assign ramAddress  = reqAddress[31:2];
  assign ramReadReq  = (state == READ);
  assign ramWriteReq = (state == WRITE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // A ready in the limit cycle still completes normally.
  assign timeoutHit = (TIMEOUT_LIMIT != 32'd0) && !ramReady &&
                      (timeoutCount == TIMEOUT_LIMIT - 32'd1);

  always_comb begin
    startIllegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (isStore && funct3[2]);
    startMisaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   startMisaligned = address[0];
      2'b10:   startMisaligned = (address[1:0] != 2'b00);
      default: startMisaligned = 1'b0;
    endcase
  end

  always_comb begin
    case (reqAddress[1:0])
      2'b00:   byteSel = ramReadData[7:0];
      2'b01:   byteSel = ramReadData[15:8];
      2'b10:   byteSel = ramReadData[23:16];
      default: byteSel = ramReadData[31:24];
    endcase
    halfSel = reqAddress[1] ? ramReadData[31:16] : ramReadData[15:0];
    case (reqFunct3)
      3'b000:  loadFormatted = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadFormatted = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadFormatted = {24'd0, byteSel};
      3'b101:  loadFormatted = {16'd0, halfSel};
      default: loadFormatted = ramReadData;
    endcase
    mergedWord = ramReadData;
    if (reqFunct3[1:0] == 2'b00) begin
      case (reqAddress[1:0])
        2'b00:   mergedWord[7:0]   = reqStoreData[7:0];
        2'b01:   mergedWord[15:8]  = reqStoreData[7:0];
        2'b10:   mergedWord[23:16] = reqStoreData[7:0];
        default: mergedWord[31:24] = reqStoreData[7:0];
      endcase
    end else if (reqAddress[1]) begin
      mergedWord[31:16] = reqStoreData;
    end else begin
      mergedWord[15:0] = reqStoreData;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (startIllegal || startMisaligned)        stateNext = DONE;
          else if (isStore && funct3 == 3'b010)       stateNext = WRITE;
          else                                        stateNext = READ;
        end
      end
      READ: begin
        if (ramReady)        stateNext = reqIsStore ? WRITE : DONE;
        else if (timeoutHit) stateNext = DONE;
      end
      WRITE: begin
        if (ramReady || timeoutHit) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      reqIsStore   <= 1'b0;
      reqFunct3    <= 3'd0;
      reqAddress   <= 32'd0;
      reqStoreData <= 16'd0;
      timeoutCount <= 32'd0;
      memoryOutput <= 32'd0;
      ramWriteData <= 32'd0;
      misaligned   <= 1'b0;
      accessFault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            reqIsStore   <= isStore;
            reqFunct3    <= funct3;
            reqAddress   <= address;
            reqStoreData <= storeData[15:0];
            timeoutCount <= 32'd0;
            accessFault  <= startIllegal;
            misaligned   <= startMisaligned && !startIllegal;
            if (isStore && funct3 == 3'b010) ramWriteData <= storeData;
          end
        end
        READ: begin
          if (ramReady) begin
            timeoutCount <= 32'd0;
            if (reqIsStore) ramWriteData <= mergedWord;
            else            memoryOutput <= loadFormatted;
          end else if (timeoutHit) begin
            accessFault <= 1'b1;
          end else begin
            timeoutCount <= timeoutCount + 32'd1;
          end
        end
        WRITE: begin
          if (!ramReady) begin
            if (timeoutHit) accessFault  <= 1'b1;
            else            timeoutCount <= timeoutCount + 32'd1;
          end
        end
        default: begin
          misaligned  <= 1'b0;
          accessFault <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle RV32I data-memory access unit driving the memory data input of the writeback rd chooser (memoryOutput), sitting upstream of it.
- Accepts one load/store per start pulse from control logic.
- Talks to a word-wide, variable-latency RAM through a req/ready handshake; performs byte/half extraction with sign/zero extension and read-modify-write for sub-word stores.
- Reports completion, misalignment and access faults back to control.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a RAM request is held without ramReady before aborting with accessFault; 0 disables timeout.

Ports:
clock  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request pulse from control; sampled only in IDLE
isStore  input  1  1 = store, 0 = load; sampled with start
funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU); sampled with start
address  input  32  byte address; sampled with start
storeData  input  32  rs2 value; sampled with start
ramAddress  output  30  word address (address[31:2] of captured request)
ramReadReq  output  1  read request, held until ramReady
ramWriteReq  output  1  write request, held until ramReady
ramWriteData  output  32  full merged word to write
ramReadData  input  32  read word, valid in cycle ramReady=1 while ramReadReq=1
ramReady  input  1  RAM completes current request this cycle
memoryOutput  output  32  formatted load result, to the rd chooser
busy  output  1  1 in any state except IDLE
done  output  1  one-cycle completion pulse
misaligned  output  1  valid with done; address not aligned to access width
accessFault  output  1  valid with done; illegal funct3 or RAM timeout

Behaviour:
- Reset (reset=0 at an edge): state IDLE; memoryOutput=0, ramAddress=0, ramWriteData=0, all req/done/misaligned/accessFault=0, timeout counter=0. Applies mid-operation: requests drop after that edge, in-flight data discarded, no done.
- States: IDLE, READ, WRITE, DONE.
- IDLE: on start, latch isStore/funct3/address/storeData, then:
  - illegal funct3 (011, 110, 111; or store with funct3[2]=1) -> DONE with accessFault=1;
  - misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> DONE with misaligned=1;
  - no RAM request in either case.
  - Otherwise: load or sub-word store -> READ; word store -> WRITE.
- start while busy is ignored.
- READ: ramReadReq=1. On an edge with ramReady=1:
  - load: memoryOutput <= formatted ramReadData, -> DONE;
  - store: merge the storeData byte/half into the read word at lane address[1:0], hold in ramWriteData, -> WRITE.
- WRITE: ramWriteReq=1, ramWriteData stable. On ramReady=1 -> DONE.
- ramReadReq and ramWriteReq are never both 1.
- DONE: done=1 for exactly one cycle, fault flags valid, -> IDLE. Flags clear on leaving DONE.
- Load formatting: byte lane = address[1:0], half lane = address[1].
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word.
- memoryOutput changes only on load completion (or reset); it holds through stores and faults.
- Timeout counter:
  - cleared on entering READ/WRITE; increments each cycle in READ/WRITE without ramReady.
  - When it reaches TIMEOUT_CYCLES (nonzero) -> DONE with accessFault=1, request dropped, memoryOutput unchanged.
  - ramReady in the same cycle as the limit wins (normal completion).
- Latency with ramReady tied 1:
  - load / word store: start at cycle N, done at N+2;
  - sub-word store: done at N+3;
  - fault: done at N+1.
- ramAddress is held constant from the cycle after start until IDLE.

Test Plan:
- RAM word 0x8000_00F0 at addr 0x100, ramReady=1; LB at 0x100 -> done at N+2, memoryOutput=0xFFFF_FFF0; LBU at 0x103 -> 0x0000_0080; LH at 0x102 -> 0xFFFF_8000.
- SB storeData=0x0000_00AB to 0x101, RAM word 0x1122_3344, ramReady=1 -> one read then one write with ramWriteData=0x1122_AB44, done at N+3, memoryOutput unchanged.
- LW at 0x104 with ramReady delayed 5 cycles -> ramReadReq held 5 cycles, done 1 cycle after ready, memoryOutput=RAM word; start pulses during busy ignored.
- LW at 0x102 and SH at 0x001 -> done at N+1, misaligned=1, no ramReadReq/ramWriteReq ever asserted; funct3=011 -> accessFault=1.
- TIMEOUT_CYCLES=4, ramReady stuck 0 on SW -> ramWriteReq high 4 cycles then drops, done with accessFault=1.
- reset=0 asserted while in READ -> next cycle IDLE, busy=0, ramReadReq=0, memoryOutput=0, no done pulse.
